// File: rtl/decimating_frame_writer.sv
// decimating_frame_writer
//
// Decimates the reconstructed camera pixel stream by 2^DECIM_LOG2 in both axes and
// writes the kept pixels into a dual-port frame-buffer BRAM. Write addresses come from
// the pixel coordinates, so a dropped pixel cannot shift the stored image. It supports
// continuous and single-shot capture, optional horizontal mirroring, frame-complete
// reporting and, with FRAME_WRITER_PINGPONG_EN defined, ping-pong buffer selection.
//
// Ports:
//   clk_in, rst_in          camera clock, asynchronous active-low reset
//   continuous_in           level: capture every frame while high
//   arm_in                  pulse: capture exactly one frame
//   mirror_in               level: store the image horizontally mirrored (per pixel)
//   pixel_*_in              pixel strobe, coordinates and data
//   wr_en/addr/data_out     registered BRAM write port (1 cycle after the input pixel)
//   frame_done_out          pulse on the last write of a complete frame
//   busy_out                high while waiting for SOF or capturing
//   frame_count_out         completed frames, wraps at 256
//   rd_buf_out              buffer holding the newest complete frame (0 without ping-pong)
//
// Macro FRAME_WRITER_PINGPONG_EN adds the buffer-select bit as the address MSB.
module decimating_frame_writer #(
    parameter int unsigned PIXEL_WIDTH = 16,
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 720,
    parameter int unsigned DECIM_LOG2  = 2,
    localparam int unsigned OUT_W      = H_ACTIVE >> DECIM_LOG2,
    localparam int unsigned OUT_H      = V_ACTIVE >> DECIM_LOG2,
    localparam int unsigned FB_DEPTH   = OUT_W * OUT_H,
    localparam int unsigned ADDR_W     = $clog2(FB_DEPTH),
`ifdef FRAME_WRITER_PINGPONG_EN
    localparam int unsigned PP         = 1
`else
    localparam int unsigned PP         = 0
`endif
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   continuous_in,
    input  logic                   arm_in,
    input  logic                   mirror_in,
    input  logic                   pixel_valid_in,
    input  logic [10:0]            pixel_hcount_in,
    input  logic [9:0]             pixel_vcount_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_data_in,
    output logic                   wr_en_out,
    output logic [ADDR_W+PP-1:0]   wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] wr_data_out,
    output logic                   frame_done_out,
    output logic                   busy_out,
    output logic [7:0]             frame_count_out,
    output logic                   rd_buf_out
);

    // Low coordinate bits that must be zero for a pixel to survive decimation.
    localparam logic [10:0] H_MASK = 11'((1 << DECIM_LOG2) - 1);
    localparam logic [9:0]  V_MASK = 10'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {StIdle, StWaitSof, StCapture} state_e;

    state_e                 state_q, state_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W+PP-1:0]   wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic [7:0]             frame_count_q, frame_count_d;
`ifdef FRAME_WRITER_PINGPONG_EN
    logic                   wr_sel_q, wr_sel_d;
    logic                   rd_buf_q, rd_buf_d;
`endif

    logic              sof, keep, last, write;
    logic [10:0]       x, col;
    logic [9:0]        y;
    logic [ADDR_W-1:0] addr_lin;

    assign sof  = pixel_valid_in && (pixel_hcount_in == '0) && (pixel_vcount_in == '0);
    assign keep = pixel_valid_in
               && (32'(pixel_hcount_in) < H_ACTIVE) && (32'(pixel_vcount_in) < V_ACTIVE)
               && ((pixel_hcount_in & H_MASK) == '0) && ((pixel_vcount_in & V_MASK) == '0);

    assign x        = pixel_hcount_in >> DECIM_LOG2;
    assign y        = pixel_vcount_in >> DECIM_LOG2;
    assign col      = mirror_in ? 11'(OUT_W - 1) - x : x;
    assign addr_lin = ADDR_W'(32'(col) + OUT_W * 32'(y));
    // Frame completion is judged on the unmirrored raster position.
    assign last     = keep && (32'(x) == OUT_W - 1) && (32'(y) == OUT_H - 1);

    always_comb begin
        state_d       = state_q;
        write         = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
`ifdef FRAME_WRITER_PINGPONG_EN
        wr_sel_d      = wr_sel_q;
        rd_buf_d      = rd_buf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (continuous_in || arm_in) state_d = StWaitSof;
            end
            StWaitSof: begin
                if (sof) begin
                    write   = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // A SOF here is a kept pixel that is not last: the frame simply
                // restarts at address 0 with nothing else to undo.
                if (keep) begin
                    write = 1'b1;
                    if (last) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
`ifdef FRAME_WRITER_PINGPONG_EN
                        wr_sel_d      = ~wr_sel_q;
                        rd_buf_d      = wr_sel_q;
`endif
                        state_d       = continuous_in ? StWaitSof : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        wr_en_d   = write;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (write) begin
`ifdef FRAME_WRITER_PINGPONG_EN
            wr_addr_d = {wr_sel_q, addr_lin};
`else
            wr_addr_d = addr_lin;
`endif
            wr_data_d = pixel_data_in;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
`ifdef FRAME_WRITER_PINGPONG_EN
            wr_sel_q      <= 1'b0;
            rd_buf_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
`ifdef FRAME_WRITER_PINGPONG_EN
            wr_sel_q      <= wr_sel_d;
            rd_buf_q      <= rd_buf_d;
`endif
        end
    end

    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign frame_done_out  = frame_done_q;
    assign busy_out        = busy_q;
    assign frame_count_out = frame_count_q;
`ifdef FRAME_WRITER_PINGPONG_EN
    assign rd_buf_out      = rd_buf_q;
`else
    assign rd_buf_out      = 1'b0;
`endif

endmodule

// File: tb/tb_decimating_frame_writer.sv
// Scoreboard bench for decimating_frame_writer on a reduced 64x32 raster, decimation 4.
module tb_decimating_frame_writer;

    localparam int PW     = 16;
    localparam int H      = 64;
    localparam int V      = 32;
    localparam int D      = 2;
    localparam int STEP   = 1 << D;
    localparam int OUT_W  = H >> D;
    localparam int OUT_H  = V >> D;
    localparam int FB     = OUT_W * OUT_H;
    localparam int AW     = $clog2(FB);
`ifdef FRAME_WRITER_PINGPONG_EN
    localparam int PP     = 1;
`else
    localparam int PP     = 0;
`endif
    localparam int HT     = H + 4;   // raster includes blanking columns/rows
    localparam int VT     = V + 2;

    logic          clk;
    logic          rst_n;
    logic          cont, arm, mirror, pvalid;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [PW-1:0] pdata;
    logic          wr_en;
    logic [AW+PP-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          frame_done, busy, rd_buf;
    logic [7:0]    frame_count;

    decimating_frame_writer #(
        .PIXEL_WIDTH(PW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .DECIM_LOG2 (D)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .continuous_in  (cont),
        .arm_in         (arm),
        .mirror_in      (mirror),
        .pixel_valid_in (pvalid),
        .pixel_hcount_in(hcount),
        .pixel_vcount_in(vcount),
        .pixel_data_in  (pdata),
        .wr_en_out      (wr_en),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .frame_done_out (frame_done),
        .busy_out       (busy),
        .frame_count_out(frame_count),
        .rd_buf_out     (rd_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit done;
        int count;
        bit rdbuf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   wr_total = 0;
    int   done_total = 0;
    bit   log_en = 0;
    int   addr_log[$];

    // Reference model: capture request / frame-in-progress flags plus counters.
    bit   m_pending, m_in_frame, m_sel, m_rd;
    int   m_count;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_pending  = 0;
        m_in_frame = 0;
        m_sel      = 0;
        m_rd       = 0;
        m_count    = 0;
    endfunction

    function automatic void model_write(input int h, input int v, input int d, input bit mir);
        int  xx   = h / STEP;
        int  yy   = v / STEP;
        bit  lst  = (xx == OUT_W - 1) && (yy == OUT_H - 1);
        int  a    = (mir ? OUT_W - 1 - xx : xx) + OUT_W * yy + (PP ? int'(m_sel) * FB : 0);
        if (lst) begin
            m_count = (m_count + 1) % 256;
            if (PP != 0) begin
                m_rd  = m_sel;
                m_sel = !m_sel;
            end
            m_in_frame = 0;
            m_pending  = cont;
        end
        q.push_back('{a, d, lst, m_count, m_rd});
    endfunction

    function automatic void model_step(input bit pv, input int h, input int v, input int d,
                                       input bit ar, input bit mir);
        bit sof  = pv && h == 0 && v == 0;
        bit keep = pv && h < H && v < V && (h % STEP) == 0 && (v % STEP) == 0;
        if (m_in_frame) begin
            if (keep) model_write(h, v, d, mir);
        end else if (m_pending) begin
            if (sof) begin
                m_pending  = 0;
                m_in_frame = 1;
                model_write(h, v, d, mir);
            end
        end else if (cont || ar) begin
            m_pending = 1;
        end
    endfunction

    task automatic drive(input bit pv, input int h, input int v, input int d,
                         input bit ar, input bit mir);
        @(negedge clk);
        pvalid = pv;
        hcount = 11'(h);
        vcount = 10'(v);
        pdata  = PW'(d);
        arm    = ar;
        mirror = mir;
        model_step(pv, h, v, d, ar, mir);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    // mir_mode: 0 off, 1 on, 2 random per pixel. Gaps are invalid cycles with junk inputs.
    task automatic stream_rows(input int r0, input int r1, input bit rnd_data,
                               input int gap_pct, input int mir_mode, input int arm_pct);
        for (int v = r0; v < r1; v++) begin
            for (int h = 0; h < HT; h++) begin
                bit mir;
                int d;
                if (int'($urandom_range(0, 99)) < gap_pct)
                    drive(0, $urandom_range(0, HT - 1), $urandom_range(0, VT - 1),
                          $urandom_range(0, 65535), 0, 1'($urandom_range(0, 1)));
                mir = (mir_mode == 2) ? 1'($urandom_range(0, 1)) : (mir_mode == 1);
                d   = rnd_data ? int'($urandom_range(0, 65535)) : (((v & 255) << 8) | (h & 255));
                drive(1, h, v, d, int'($urandom_range(0, 99)) < arm_pct, mir);
            end
        end
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes actual=%0d pending required=0", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: every write pops and checks one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (frame_done) check("done_with_write", wr_en, 1);
                if (wr_en) begin
                    wr_total++;
                    if (frame_done) done_total++;
                    if (log_en) addr_log.push_back(int'(wr_addr));
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual addr=%0d required=no write",
                                 wr_addr);
                    end else begin
                        e = q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                        check("frame_done", frame_done, e.done);
                        check("frame_count", frame_count, e.count);
                        check("rd_buf", rd_buf, e.rdbuf);
                    end
                end
            end
        end
    end

    initial begin
        int w0, d0, c0;
        rst_n = 0; cont = 0; arm = 0; mirror = 0; pvalid = 0;
        hcount = '0; vcount = '0; pdata = '0;
        model_reset();
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", frame_count, 0);
        check("rst_rd_buf", rd_buf, 0);
        @(negedge clk);
        rst_n = 1;

        // Continuous capture of a full frame with coordinate-encoded data.
        cont = 1;
        idle(3);
        w0 = wr_total;
        stream_rows(0, VT, 0, 0, 0, 0);
        drain("frame1");
        check("frame1_writes", wr_total - w0, FB);
        check("frame1_count", frame_count, 1);
        check("frame1_busy", busy, 1);

        // Two more frames with random data, mirror and gaps.
        stream_rows(0, VT, 1, 10, 2, 0);
        stream_rows(0, VT, 1, 10, 2, 0);
        drain("rand_frames");
        check("rand_count", frame_count, m_count);

        // Continuous drops mid-frame: frame completes, then idle.
        stream_rows(0, 10, 1, 5, 0, 0);
        cont = 0;
        stream_rows(10, VT, 1, 5, 0, 0);
        drain("cont_fall");
        check("cont_fall_busy", busy, 0);
        check("cont_fall_count", frame_count, 4);

        // Continuous raised mid-frame: nothing until the next SOF.
        w0 = wr_total;
        stream_rows(0, V / 2, 1, 0, 0, 0);
        cont = 1;
        stream_rows(V / 2, VT, 1, 0, 0, 0);
        drain("late_cont");
        check("late_cont_no_writes", wr_total - w0, 0);
        stream_rows(0, VT, 1, 0, 0, 0);
        drain("late_cont_frame");
        check("late_cont_count", frame_count, 5);

        // SOF injected mid-capture aborts; next full frame completes once.
        d0 = done_total;
        stream_rows(0, 20, 1, 0, 0, 0);
        stream_rows(0, VT, 1, 0, 0, 0);
        drain("sof_inject");
        check("sof_inject_dones", done_total - d0, 1);
        check("sof_inject_count", frame_count, 6);

        // Mirrored frame; continuous drops after row 1 so the block ends idle.
        addr_log.delete();
        log_en = 1;
        stream_rows(0, 2, 1, 0, 1, 0);
        cont = 0;
        stream_rows(2, VT, 1, 0, 1, 0);
        drain("mirror");
        log_en = 0;
        check("mirror_h0_v0", addr_log[0] % FB, OUT_W - 1);
        check("mirror_hlast_v0", addr_log[OUT_W - 1] % FB, 0);
        check("mirror_h0_v4", addr_log[OUT_W] % FB, 2 * OUT_W - 1);
        check("mirror_busy", busy, 0);

        // Single-shot: only the first of two frames is written.
        c0 = frame_count;
        w0 = wr_total;
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        check("arm_busy", busy, 1);
        stream_rows(0, VT, 1, 5, 2, 0);
        stream_rows(0, VT, 1, 5, 2, 0);
        drain("single_shot");
        check("single_writes", wr_total - w0, FB);
        check("single_count", frame_count, (c0 + 1) % 256);
        check("single_busy", busy, 0);

        // Random control stress including stray arm pulses and truncated frames.
        for (int f = 0; f < 3; f++) begin
            cont = 1'($urandom_range(0, 1));
            stream_rows(0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, VT - 1)) : VT,
                        1, 8, 2, 1);
        end
        drain("stress");
        check("stress_count", frame_count, m_count);

        // Asynchronous reset in the middle of a capture.
        cont = 1;
        idle(2);
        stream_rows(0, 8, 1, 0, 0, 0);
        drive(1, 0, 8, 16'h1234, 0, 0);
        @(posedge clk);
        #3;
        check("pre_reset_wr_en", wr_en, 1);
        rst_n = 0;
        #1;
        check("async_wr_en", wr_en, 0);
        check("async_wr_addr", wr_addr, 0);
        check("async_wr_data", wr_data, 0);
        check("async_done", frame_done, 0);
        check("async_busy", busy, 0);
        check("async_count", frame_count, 0);
        check("async_rd_buf", rd_buf, 0);
        q.delete();
        model_reset();
        cont = 0;
        pvalid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        drain("post_reset");
        check("post_reset_count", frame_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decimating_frame_writer.md
Name: decimating_frame_writer

Overview:
- Parametrised successor to the camera-side frame-buffer write logic.
- Takes the reconstructed camera pixel stream (valid, hcount, vcount, data) and decimates it by 2^DECIM_LOG2 in both dimensions.
- Computes write addresses directly from pixel coordinates instead of a free-running counter, so the frame buffer stays aligned to frame start. Dropped pixels cannot skew the image.
- Adds continuous and single-shot capture modes, optional horizontal mirroring, frame-complete reporting, and optional ping-pong buffering. Sits between pixel_reconstruct and the dual-port frame-buffer BRAM write port.

Parameters:
- PIXEL_WIDTH, 16, pixel data width (565 RGB by default).
- H_ACTIVE, 1280, active camera pixels per line.
- V_ACTIVE, 720, active camera lines per frame.
- DECIM_LOG2, 2, log2 of the decimation factor per axis; 0 means no decimation.
- Derived values (not overridable):
  - OUT_W = H_ACTIVE>>DECIM_LOG2
  - OUT_H = V_ACTIVE>>DECIM_LOG2
  - FB_DEPTH = OUT_W*OUT_H
  - ADDR_W = $clog2(FB_DEPTH)
  - PP = 1 when FRAME_WRITER_PINGPONG_EN is defined, else 0

Ports:
- clk_in  input  1  single clock for the block (camera domain).
- rst_in  input  1  asynchronous, active-low reset.
- continuous_in  input  1  level; capture every frame while high.
- arm_in  input  1  one-cycle pulse; capture exactly one frame.
- mirror_in  input  1  level; mirror the image horizontally in memory; sampled per pixel.
- pixel_valid_in  input  1  pixel strobe.
- pixel_hcount_in  input  11  pixel column.
- pixel_vcount_in  input  10  pixel row.
- pixel_data_in  input  PIXEL_WIDTH  pixel value.
- wr_en_out  output  1  BRAM write enable.
- wr_addr_out  output  ADDR_W+PP  BRAM write address.
- wr_data_out  output  PIXEL_WIDTH  BRAM write data.
- frame_done_out  output  1  one-cycle pulse, coincident with the last write of a complete frame.
- busy_out  output  1  high in WAIT_SOF or CAPTURE.
- frame_count_out  output  8  count of completed frames; wraps 255->0.
- rd_buf_out  output  1  buffer holding the most recent complete frame.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state=IDLE.
  - All outputs 0: wr_en, wr_addr, wr_data, frame_done, busy, frame_count, rd_buf.
  - Internal write-buffer select = 0.
- Definitions:
  - SOF = pixel_valid_in && hcount==0 && vcount==0.
  - keep = pixel_valid_in && hcount<H_ACTIVE && vcount<V_ACTIVE && hcount[DECIM_LOG2-1:0]==0 && vcount[DECIM_LOG2-1:0]==0.
  - When DECIM_LOG2=0, the low-bit tests are always true.
- Address:
  - x = hcount>>DECIM_LOG2, y = vcount>>DECIM_LOG2.
  - col = mirror_in ? OUT_W-1-x : x.
  - addr = col + OUT_W*y (constant multiply); the ping-pong select bit, when present, is prepended as MSB.
- Latency: outputs are registered; a kept input pixel appears on wr_* exactly 1 cycle later. wr_en_out is high only for kept pixels in CAPTURE, or on the SOF pixel that causes the transition into CAPTURE.
- States:
  - IDLE:
    - No writes.
    - continuous_in=1 or arm_in=1 -> WAIT_SOF.
  - WAIT_SOF:
    - No writes.
    - arm_in ignored.
    - On SOF: that pixel is written (addr of x=0,y=0, mirroring applied) -> CAPTURE.
  - CAPTURE:
    - Write each kept pixel.
    - Last pixel = kept with x==OUT_W-1 && y==OUT_H-1 (unmirrored coordinates):
      - frame_done_out pulses in the same cycle that write appears on wr_*.
      - frame_count increments.
      - Next state = continuous_in ? WAIT_SOF : IDLE.
    - SOF before the last pixel means the frame is incomplete:
      - No frame_done, count unchanged, buffer not toggled.
      - The SOF pixel is written.
      - Remain in CAPTURE, restarting the frame.
    - continuous_in falling mid-frame: the current frame still completes, then IDLE.
    - arm_in is ignored.
- busy_out is registered and reflects the state one cycle after the transition.
- Pixels outside the active area, or with pixel_valid_in low, never write in any state.

Optional Feature:
- Macro: FRAME_WRITER_PINGPONG_EN.
- Defined:
  - wr_addr_out is ADDR_W+1 bits; MSB = internal write-buffer select.
  - On frame_done, the select toggles for the next frame, and rd_buf_out takes the just-completed buffer's index in that same cycle.
  - Aborted frames do not toggle.
  - This lets HDMI readout use the completed buffer without tearing.
- Undefined:
  - wr_addr_out is ADDR_W bits.
  - rd_buf_out is tied 0.

Test Plan:
- Reset, continuous_in=1, stream a full 1280x720 frame with data={vcount[7:0],hcount[7:0]}:
  - Exactly 57600 writes, addresses 0..57599 ascending.
  - First write carries data 0x0000.
  - frame_done pulses once, with addr 57599; frame_count_out=1.
- continuous_in raised at vcount=300: no wr_en until the next SOF; then the first write is addr 0.
- arm_in pulse, then two full frames streamed: only the first frame is written; busy_out low afterwards; frame_count_out=1.
- mirror_in=1, pixel at hcount=0, vcount=4 -> wr_addr_out=639; at hcount=1276, vcount=0 -> wr_addr_out=0.
- SOF injected at vcount=400 mid-capture:
  - No frame_done; the next write is addr 0.
  - The following complete frame gives frame_done; frame_count_out=1.
- Assert rst_in low mid-capture: all outputs are 0 immediately, without waiting for a clock edge.
- With FRAME_WRITER_PINGPONG_EN:
  - Frame 1 addresses have MSB=0; after its done, rd_buf_out=0.
  - Frame 2 addresses have MSB=1; after its done, rd_buf_out=1.
